// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: a circular byte FIFO feeding a three-state
// launch/handshake sequencer that hands one frame at a time to the transmitter.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no frame in flight; launches when enabled and FIFO has data
// REQ       | start_tx_o held high with data until the transmitter acks
// WAIT_DONE | frame on the wire; data held stable until tx_done_i
module uart_tx_ctrl #(
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          tx_en_i,
   input  logic          wr_en_i,
   input  logic [7:0]    wr_data_i,
   input  logic          flush_i,
   output logic          fifo_full_o,
   output logic          fifo_empty_o,
   output logic [CW-1:0] fifo_count_o,
   output logic          overflow_o,
   output logic [31:0]   tx_data_o,
   output logic          start_tx_o,
   input  logic          tx_start_ack_i,
   input  logic          tx_done_i,
   output logic          busy_o,
   output logic          tx_irq_o
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REQ       = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    tx_byte_q, tx_byte_d;
   logic          start_q, start_d;
   logic          ovf_q, ovf_d;
   logic          irq_q, irq_d;
   logic [7:0]    mem_q [DEPTH];

   logic full, empty, push, pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   // Flush wins over both FIFO ports; a full FIFO drops the push even if a pop frees a slot.
   assign push  = wr_en_i && !full && !flush_i;
   assign pop   = (state_q == IDLE) && tx_en_i && !empty && !flush_i;

   // Next-state computation for FIFO bookkeeping and the launch sequencer.
   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      tx_byte_d = tx_byte_q;
      start_d   = start_q;
      ovf_d     = wr_en_i && full && !flush_i;
      irq_d     = 1'b0;

      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end

      case (state_q)
         IDLE: begin
            if (pop) begin
               state_d   = REQ;
               tx_byte_d = mem_q[rd_ptr_q];
               start_d   = 1'b1;
            end
         end
         REQ: begin
            // tx_done_i is deliberately ignored here; only the ack moves us on.
            if (tx_start_ack_i) begin
               state_d = WAIT_DONE;
               start_d = 1'b0;
            end
         end
         WAIT_DONE: begin
            start_d = 1'b0;
            if (tx_done_i) begin
               state_d = IDLE;
               irq_d   = (count_d == '0);
            end
         end
         default: begin
            state_d = IDLE;
            start_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         tx_byte_q <= '0;
         start_q   <= 1'b0;
         ovf_q     <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         tx_byte_q <= tx_byte_d;
         start_q   <= start_d;
         ovf_q     <= ovf_d;
         irq_q     <= irq_d;
      end
   end

   // FIFO storage; contents are don't-care after reset since the pointers are cleared.
   always_ff @(posedge clk) begin
      if (reset_n && push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign fifo_full_o  = full;
   assign fifo_empty_o = empty;
   assign fifo_count_o = count_q;
   assign overflow_o   = ovf_q;
   assign tx_data_o    = {24'h0, tx_byte_q};
   assign start_tx_o   = start_q;
   assign busy_o       = (state_q != IDLE) || !empty;
   assign tx_irq_o     = irq_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: bytes expected on the transmitter side are
// queued when pushed; a monitor pops and compares on every new start_tx_o.
module tb_uart_tx_ctrl;

   localparam int DEPTH = 8;
   localparam int CW    = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          tx_en_i = 1'b0;
   logic          wr_en_i = 1'b0;
   logic [7:0]    wr_data_i = 8'h00;
   logic          flush_i = 1'b0;
   logic          tx_start_ack_i = 1'b0;
   logic          tx_done_i = 1'b1;
   logic          fifo_full_o, fifo_empty_o, overflow_o, start_tx_o, busy_o, tx_irq_o;
   logic [CW-1:0] fifo_count_o;
   logic [31:0]   tx_data_o;

   uart_tx_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .tx_en_i       (tx_en_i),
      .wr_en_i       (wr_en_i),
      .wr_data_i     (wr_data_i),
      .flush_i       (flush_i),
      .fifo_full_o   (fifo_full_o),
      .fifo_empty_o  (fifo_empty_o),
      .fifo_count_o  (fifo_count_o),
      .overflow_o    (overflow_o),
      .tx_data_o     (tx_data_o),
      .start_tx_o    (start_tx_o),
      .tx_start_ack_i(tx_start_ack_i),
      .tx_done_i     (tx_done_i),
      .busy_o        (busy_o),
      .tx_irq_o      (tx_irq_o)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   int         frames = 0;
   int         irq_cnt = 0;
   int         ovf_cnt = 0;
   int         ack_delay = 0;
   int         frame_len = 3;
   logic       prev_start = 1'b0;
   int         xs = 0;
   int         xcnt = 0;
   logic       s_start, s_rst;
   int         irq0, ovf0, fr0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy_o !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain_to_idle", {31'h0, busy_o}, 32'h0);
      @(negedge clk);
   endtask

   task automatic wait_start(input logic lvl, input int budget);
      int n = 0;
      @(negedge clk);
      while (start_tx_o !== lvl && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("start_wait", {31'h0, start_tx_o}, {31'h0, lvl});
   endtask

   task automatic push1(input logic [7:0] b, input bit expect_sent);
      wr_en_i   = 1'b1;
      wr_data_i = b;
      if (expect_sent) exp_q.push_back(b);
      tick();
   endtask

   // Transmitter model: acks after ack_delay, drops done during the frame, shares reset.
   initial begin
      forever begin
         @(negedge clk);
         s_start = start_tx_o;
         s_rst   = reset_n;
         @(posedge clk);
         #1;
         if (!s_rst) begin
            tx_start_ack_i = 1'b0;
            tx_done_i      = 1'b1;
            xs             = 0;
         end else begin
            case (xs)
               0: if (s_start) begin
                     if (ack_delay == 0) begin
                        tx_start_ack_i = 1'b1;
                        tx_done_i      = 1'b0;
                        xs             = 2;
                     end else begin
                        xcnt = ack_delay;
                        xs   = 1;
                     end
                  end
               1: begin
                     xcnt--;
                     if (xcnt == 0) begin
                        tx_start_ack_i = 1'b1;
                        tx_done_i      = 1'b0;
                        xs             = 2;
                     end
                  end
               2: begin
                     tx_start_ack_i = 1'b0;
                     xcnt           = frame_len;
                     xs             = 3;
                  end
               default: begin
                     xcnt--;
                     if (xcnt == 0) begin
                        tx_done_i = 1'b1;
                        xs        = 0;
                     end
                  end
            endcase
         end
      end
   end

   // Monitor: compare each launched frame against the scoreboard queue.
   always @(negedge clk) begin
      if (start_tx_o && !prev_start) begin
         frames++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got data 0x%0h with no frame expected", tx_data_o);
         end else begin
            chk("frame_data", tx_data_o, {24'h0, exp_q.pop_front()});
         end
      end
      if (tx_irq_o) begin
         irq_cnt++;
         chk("irq_pending_frames", exp_q.size(), 0);
      end
      if (overflow_o) ovf_cnt++;
      prev_start = start_tx_o;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_tx_data", tx_data_o, 32'h0);
      chk("rst_start", {31'h0, start_tx_o}, 32'h0);
      chk("rst_overflow", {31'h0, overflow_o}, 32'h0);
      chk("rst_irq", {31'h0, tx_irq_o}, 32'h0);
      chk("rst_empty", {31'h0, fifo_empty_o}, 32'h1);
      chk("rst_full", {31'h0, fifo_full_o}, 32'h0);
      chk("rst_busy", {31'h0, busy_o}, 32'h0);
      chk("rst_count", {28'h0, fifo_count_o}, 32'h0);
      tick();
      reset_n = 1'b1;

      // Single byte, two-edge launch latency
      tx_en_i = 1'b1;
      irq0 = irq_cnt;
      tick();
      push1(8'hA5, 1'b1);
      wr_en_i = 1'b0;
      @(negedge clk);
      chk("s1_start_edge1", {31'h0, start_tx_o}, 32'h0);
      chk("s1_count_edge1", {28'h0, fifo_count_o}, 32'h1);
      @(negedge clk);
      chk("s1_start_edge2", {31'h0, start_tx_o}, 32'h1);
      chk("s1_data_edge2", tx_data_o, 32'h0000_00A5);
      chk("s1_count_edge2", {28'h0, fifo_count_o}, 32'h0);
      repeat (2) @(negedge clk);
      chk("s1_start_after_ack", {31'h0, start_tx_o}, 32'h0);
      chk("s1_busy_wait_done", {31'h0, busy_o}, 32'h1);
      wait_idle(50);
      chk("s1_irq_once", irq_cnt - irq0, 1);

      // Fill and overflow, then drain in order
      tick();
      tx_en_i = 1'b0;
      irq0 = irq_cnt;
      ovf0 = ovf_cnt;
      fr0  = frames;
      for (int i = 0; i < 9; i++) push1(8'h10 + 8'(i), i < 8);
      wr_en_i = 1'b0;
      @(negedge clk);
      chk("s2_overflow_pulse", {31'h0, overflow_o}, 32'h1);
      chk("s2_count_full", {28'h0, fifo_count_o}, 32'h8);
      chk("s2_full", {31'h0, fifo_full_o}, 32'h1);
      chk("s2_no_launch_disabled", frames - fr0, 0);
      tick();
      tx_en_i = 1'b1;
      @(negedge clk);
      chk("s2_overflow_one_cycle", {31'h0, overflow_o}, 32'h0);
      wait_idle(400);
      chk("s2_overflow_count", ovf_cnt - ovf0, 1);
      chk("s2_irq_once", irq_cnt - irq0, 1);
      chk("s2_frames", frames - fr0, 8);
      chk("s2_queue_drained", exp_q.size(), 0);

      // Delayed ack: request and data held, no further pop
      ack_delay = 20;
      irq0 = irq_cnt;
      fr0  = frames;
      tick();
      push1(8'h3C, 1'b1);
      push1(8'h5A, 1'b1);
      wr_en_i = 1'b0;
      wait_start(1'b1, 10);
      for (int i = 0; i < 20; i++) begin
         chk("s3_start_held", {31'h0, start_tx_o}, 32'h1);
         chk("s3_data_held", tx_data_o, 32'h0000_003C);
         chk("s3_count_held", {28'h0, fifo_count_o}, 32'h1);
         @(negedge clk);
      end
      ack_delay = 0;
      wait_idle(200);
      chk("s3_frames", frames - fr0, 2);
      chk("s3_irq_once", irq_cnt - irq0, 1);

      // Flush during WAIT_DONE of frame 1
      frame_len = 6;
      irq0 = irq_cnt;
      fr0  = frames;
      tick();
      push1(8'h01, 1'b1);
      push1(8'h02, 1'b0);
      push1(8'h03, 1'b0);
      wr_en_i = 1'b0;
      wait_start(1'b1, 10);
      wait_start(1'b0, 20);
      chk("s4_count_pre_flush", {28'h0, fifo_count_o}, 32'h2);
      tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      @(negedge clk);
      chk("s4_count_flushed", {28'h0, fifo_count_o}, 32'h0);
      chk("s4_empty_flushed", {31'h0, fifo_empty_o}, 32'h1);
      chk("s4_busy_in_frame", {31'h0, busy_o}, 32'h1);
      chk("s4_data_kept", tx_data_o, 32'h0000_0001);
      wait_idle(100);
      repeat (10) @(negedge clk);
      chk("s4_irq_once", irq_cnt - irq0, 1);
      chk("s4_frames", frames - fr0, 1);

      // Concurrent push/pop with count 4 across the pointer wrap
      frame_len = 3;
      tick();
      for (int i = 0; i < 6; i++) push1(8'h20 + 8'(i), 1'b1);
      wr_en_i = 1'b0;
      wait_idle(300);
      fr0 = frames;
      tick();
      tx_en_i = 1'b0;
      for (int i = 0; i < 4; i++) push1(8'h40 + 8'(i), 1'b1);
      wr_en_i = 1'b0;
      @(negedge clk);
      chk("s5_count_pre", {28'h0, fifo_count_o}, 32'h4);
      tick();
      tx_en_i = 1'b1;
      push1(8'h44, 1'b1);
      wr_en_i = 1'b0;
      @(negedge clk);
      chk("s5_count_concurrent", {28'h0, fifo_count_o}, 32'h4);
      chk("s5_launch", {31'h0, start_tx_o}, 32'h1);
      wait_idle(300);
      chk("s5_frames", frames - fr0, 5);
      chk("s5_queue_drained", exp_q.size(), 0);

      // Reset in WAIT_DONE abandons the frame and empties the FIFO
      frame_len = 10;
      irq0 = irq_cnt;
      fr0  = frames;
      tick();
      push1(8'h77, 1'b1);
      push1(8'h88, 1'b0);
      wr_en_i = 1'b0;
      wait_start(1'b1, 10);
      wait_start(1'b0, 20);
      chk("s6_count_pre", {28'h0, fifo_count_o}, 32'h1);
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      @(negedge clk);
      chk("s6_tx_data", tx_data_o, 32'h0);
      chk("s6_start", {31'h0, start_tx_o}, 32'h0);
      chk("s6_overflow", {31'h0, overflow_o}, 32'h0);
      chk("s6_irq", {31'h0, tx_irq_o}, 32'h0);
      chk("s6_empty", {31'h0, fifo_empty_o}, 32'h1);
      chk("s6_full", {31'h0, fifo_full_o}, 32'h0);
      chk("s6_busy", {31'h0, busy_o}, 32'h0);
      chk("s6_count", {28'h0, fifo_count_o}, 32'h0);
      repeat (15) @(negedge clk);
      chk("s6_no_relaunch", frames - fr0, 1);
      chk("s6_no_irq", irq_cnt - irq0, 0);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
